// File: rtl/serial_divider.sv
// Serial unsigned restoring divider.
// Accepts one dividend/divisor pair in IDLE, produces one quotient bit per
// cycle in RUN (MSB first), then holds the result in DONE until the consumer
// takes it. A zero divisor bypasses RUN and returns quotient = all ones and
// remainder = dividend with div_by_zero flagged.
module serial_divider #(
  parameter int BITWIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BITWIDTH-1:0] dividend,
  input  logic [BITWIDTH-1:0] divisor,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BITWIDTH-1:0] quotient,
  output logic [BITWIDTH-1:0] remainder,
  output logic                div_by_zero
);

  localparam int CW = $clog2(BITWIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q;
  logic [BITWIDTH-1:0] dvd_q;
  logic [BITWIDTH-1:0] dvs_q;
  logic [BITWIDTH-1:0] prem_q;
  logic [BITWIDTH-1:0] quo_q;
  logic [CW-1:0]       step_q;
  logic                out_valid_q;
  logic [BITWIDTH-1:0] quotient_q;
  logic [BITWIDTH-1:0] remainder_q;
  logic                dbz_q;

  logic [BITWIDTH:0]   shift_d;
  logic [BITWIDTH:0]   diff_d;
  logic [BITWIDTH-1:0] prem_d;
  logic [BITWIDTH-1:0] quo_d;
  logic                last_step_d;

  // in_ready depends only on the state register, so no input reaches it combinationally.
  assign in_ready    = (state_q == IDLE);
  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

  // One restoring step: shift in the next dividend bit and trial-subtract the divisor.
  // The partial remainder is always below the divisor, so the top bit of the
  // (BITWIDTH+1)-bit difference is set exactly when the subtraction underflowed.
  always_comb begin
    shift_d     = {prem_q, dvd_q[BITWIDTH-1]};
    diff_d      = shift_d - {1'b0, dvs_q};
    prem_d      = shift_d[BITWIDTH-1:0];
    quo_d       = {quo_q[BITWIDTH-2:0], 1'b0};
    last_step_d = (step_q == CW'(BITWIDTH - 1));
    if (!diff_d[BITWIDTH]) begin
      prem_d = diff_d[BITWIDTH-1:0];
      quo_d  = {quo_q[BITWIDTH-2:0], 1'b1};
    end
  end

  // Control FSM with registered result outputs; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      dvd_q       <= '0;
      dvs_q       <= '0;
      prem_q      <= '0;
      quo_q       <= '0;
      step_q      <= '0;
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (divisor == '0) begin
              quotient_q  <= '1;
              remainder_q <= dividend;
              dbz_q       <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              dvd_q   <= dividend;
              dvs_q   <= divisor;
              prem_q  <= '0;
              quo_q   <= '0;
              step_q  <= '0;
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          prem_q <= prem_d;
          quo_q  <= quo_d;
          dvd_q  <= dvd_q << 1;
          step_q <= step_q + CW'(1);
          if (last_step_d) begin
            quotient_q  <= quo_d;
            remainder_q <= prem_d;
            dbz_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_divider.sv
// Directed self-checking bench for serial_divider at BITWIDTH = 8.
module tb_serial_divider;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int checkCount = 0;
  int failCount  = 0;

  serial_divider #(.BITWIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts one comparison and reports it when observed and expected differ.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Advances one clock edge and settles just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one division: waits for in_ready, presents the operands for one edge,
  // measures edges from accept to out_valid, optionally stalls the consumer,
  // then completes the output handshake.
  task automatic applyStimulus(input string tag, input logic [7:0] a, input logic [7:0] b,
                               input int expQ, input int expR, input int expDbz,
                               input int expLat, input int holdCycles);
    int lat;
    int wait_cnt;
    wait_cnt = 0;
    while (!in_ready && wait_cnt < 40) begin
      tick();
      wait_cnt++;
    end
    checkOutput({tag, "_ready"}, 32'(in_ready), 32'd1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    checkOutput({tag, "_lat"}, 32'(lat), 32'(expLat));
    checkOutput({tag, "_q"}, 32'(quotient), 32'(expQ));
    checkOutput({tag, "_r"}, 32'(remainder), 32'(expR));
    checkOutput({tag, "_dbz"}, 32'(div_by_zero), 32'(expDbz));
    for (int i = 0; i < holdCycles; i++) begin
      tick();
      checkOutput({tag, "_hold_v"}, 32'(out_valid), 32'd1);
      checkOutput({tag, "_hold_q"}, 32'(quotient), 32'(expQ));
      checkOutput({tag, "_hold_r"}, 32'(remainder), 32'(expR));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput({tag, "_post_ready"}, 32'(in_ready), 32'd1);
    checkOutput({tag, "_post_valid"}, 32'(out_valid), 32'd0);
  endtask

  // Main directed sequence.
  initial begin
    int results;
    int acceptIdx;
    logic [7:0] ta;
    logic [7:0] tb;

    rst       = 1'b0;
    in_valid  = 1'b1;
    dividend  = 8'd37;
    divisor   = 8'd0;
    out_ready = 1'b0;
    repeat (3) tick();
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_q", 32'(quotient), 32'd0);
    checkOutput("rst_r", 32'(remainder), 32'd0);
    checkOutput("rst_dbz", 32'(div_by_zero), 32'd0);
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    checkOutput("rst_rel_ready", 32'(in_ready), 32'd1);

    applyStimulus("d100_7", 8'd100, 8'd7, 14, 2, 0, 8, 0);
    applyStimulus("d255_1", 8'd255, 8'd1, 255, 0, 0, 8, 0);
    applyStimulus("d5_9", 8'd5, 8'd9, 0, 5, 0, 8, 0);
    applyStimulus("d37_0", 8'd37, 8'd0, 255, 37, 1, 0, 0);
    applyStimulus("d200_3", 8'd200, 8'd3, 66, 2, 0, 8, 5);
    applyStimulus("d0_5", 8'd0, 8'd5, 0, 0, 0, 8, 0);
    applyStimulus("d128_128", 8'd128, 8'd128, 1, 0, 0, 8, 0);

    // Reset four edges into RUN: abandoned operation, cleared outputs.
    dividend = 8'd100;
    divisor  = 8'd7;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checkOutput("midrst_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_ready", 32'(in_ready), 32'd1);
    checkOutput("midrst_q", 32'(quotient), 32'd0);
    checkOutput("midrst_r", 32'(remainder), 32'd0);
    checkOutput("midrst_dbz", 32'(div_by_zero), 32'd0);
    applyStimulus("d9_3", 8'd9, 8'd3, 3, 0, 0, 8, 0);

    // in_valid held high with operands changing every cycle; with out_ready high
    // the block accepts every 10 edges (accept, 8 steps, handshake), so only
    // the operands offered at cycles 0, 10 and 20 produce results.
    out_ready = 1'b1;
    results   = 0;
    for (int c = 0; c < 30; c++) begin
      dividend = 8'((c * 37 + 11) % 256);
      divisor  = 8'((c % 7) + 1);
      in_valid = 1'b1;
      tick();
      if (out_valid) begin
        acceptIdx = results * 10;
        ta = 8'((acceptIdx * 37 + 11) % 256);
        tb = 8'((acceptIdx % 7) + 1);
        checkOutput("stream_q", 32'(quotient), 32'(ta / tb));
        checkOutput("stream_r", 32'(remainder), 32'(ta % tb));
        results++;
      end
    end
    in_valid  = 1'b0;
    checkOutput("stream_count", 32'(results), 32'd3);
    repeat (12) tick();
    out_ready = 1'b0;
    checkOutput("stream_idle", 32'(in_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
